// File: rtl/tm1638_pkg.sv
// Shared definitions for the TM1638 LED&KEY controller: bus command bytes,
// state encodings and the hex-to-seven-segment font.
// Optional feature macro: TM1638_LED_EN (adds the LED state).
package tm1638_pkg;

  localparam logic [7:0] CMD_DISP_ON     = 8'h8F;
  localparam logic [7:0] CMD_READ        = 8'h42;
  localparam logic [7:0] CMD_WRITE_FIXED = 8'h44;
  localparam logic [7:0] CMD_ADDR_BASE   = 8'hC0;

  typedef enum logic [2:0] {
    RESET_WAIT,
    INIT,
    READ,
    MODE,
    DIGIT
`ifdef TM1638_LED_EN
    , LED
`endif
  } top_state_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LO,
    S_HI,
    S_HOLD,
    S_GAP
  } ser_state_t;

  typedef enum logic {
    DIR_WRITE = 1'b0,
    DIR_READ  = 1'b1
  } dir_t;

  // Standard hex font, bit0 = a ... bit6 = g, DP off
  function automatic logic [7:0] hex_to_seg(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0: s = 8'h3F;
      4'h1: s = 8'h06;
      4'h2: s = 8'h5B;
      4'h3: s = 8'h4F;
      4'h4: s = 8'h66;
      4'h5: s = 8'h6D;
      4'h6: s = 8'h7D;
      4'h7: s = 8'h07;
      4'h8: s = 8'h7F;
      4'h9: s = 8'h6F;
      4'hA: s = 8'h77;
      4'hB: s = 8'h7C;
      4'hC: s = 8'h39;
      4'hD: s = 8'h5E;
      4'hE: s = 8'h79;
      default: s = 8'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/tm1638_serial.sv
// TM1638 byte engine: shifts one byte LSB first on the three-wire bus.
// Owns STB/CLK generation, the DIO tristate and half-period timing.
// With keep set, STB stays low after the byte so the next byte joins the
// same frame; otherwise STB rises one half-period after the last bit and
// stays high for the inter-frame gap before done is reported.
module tm1638_serial
  import tm1638_pkg::*;
#(
  parameter int unsigned CLOCK_SLOW = 11,
  parameter int unsigned WRITE_SLOW = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] tx,
  input  dir_t       dir,
  input  logic       keep,
  output logic       done,
  output logic [7:0] rx,
  output logic       stb,
  output logic       sclk,
  inout  wire        dio
);

  localparam logic [15:0] HALF = 16'(CLOCK_SLOW);
  localparam logic [15:0] GAP  = 16'(WRITE_SLOW);

  ser_state_t  state, state_d;
  logic [15:0] cnt, cnt_d;
  logic [2:0]  bit_idx, bit_d;
  logic [7:0]  sh, sh_d;
  logic [7:0]  rx_d;
  dir_t        dir_q, dir_d;
  logic        keep_q, keep_d;
  logic        stb_d, sclk_d, done_d;
  logic        dio_oe, oe_d;
  logic        dio_out, out_d;

  assign dio = dio_oe ? dio_out : 1'bz;

  // State and bus output registers; reset aborts any frame immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '0;
      rx      <= '0;
      dir_q   <= DIR_WRITE;
      keep_q  <= 1'b0;
      stb     <= 1'b1;
      sclk    <= 1'b1;
      done    <= 1'b0;
      dio_oe  <= 1'b0;
      dio_out <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_d;
      sh      <= sh_d;
      rx      <= rx_d;
      dir_q   <= dir_d;
      keep_q  <= keep_d;
      stb     <= stb_d;
      sclk    <= sclk_d;
      done    <= done_d;
      dio_oe  <= oe_d;
      dio_out <= out_d;
    end
  end

  // Bit sequencing: CLK falls and data changes, CLK rises and data is sampled
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    bit_d   = bit_idx;
    sh_d    = sh;
    rx_d    = rx;
    dir_d   = dir_q;
    keep_d  = keep_q;
    stb_d   = stb;
    sclk_d  = sclk;
    oe_d    = dio_oe;
    out_d   = dio_out;
    done_d  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          sh_d   = tx;
          dir_d  = dir;
          keep_d = keep;
          bit_d  = '0;
          cnt_d  = '0;
          if (stb) begin
            stb_d   = 1'b0;
            state_d = S_SETUP;
          end else begin
            state_d = S_LO;
            sclk_d  = 1'b0;
            oe_d    = (dir == DIR_WRITE);
            out_d   = tx[0];
          end
        end
      end
      S_SETUP: begin
        if (cnt == HALF) begin
          cnt_d   = '0;
          state_d = S_LO;
          sclk_d  = 1'b0;
          oe_d    = (dir_q == DIR_WRITE);
          out_d   = sh[0];
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      S_LO: begin
        if (cnt == HALF) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          state_d = S_HI;
          if (dir_q == DIR_READ) rx_d = {dio, rx[7:1]};
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      S_HI: begin
        if (cnt == HALF) begin
          cnt_d = '0;
          if (bit_idx == 3'd7) begin
            oe_d = 1'b0;
            if (keep_q) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = S_HOLD;
            end
          end else begin
            bit_d   = bit_idx + 3'd1;
            sh_d    = {1'b0, sh[7:1]};
            state_d = S_LO;
            sclk_d  = 1'b0;
            out_d   = sh[1];
          end
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      S_HOLD: begin
        if (cnt == HALF) begin
          cnt_d   = '0;
          stb_d   = 1'b1;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      S_GAP: begin
        if (cnt == GAP) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: rtl/tm1638_btm_disp.sv
// TM1638 LED&KEY controller: polls the eight buttons and shows them as an
// 8-digit hex value. Sequence: init (0x8F) once, then forever read keys,
// fixed-address mode, one digit write; digit index wraps 7 -> 0.
// Optional macro TM1638_LED_EN adds one LED frame per digit mirroring K[d].
module tm1638_btm_disp
  import tm1638_pkg::*;
#(
  parameter int unsigned CLOCK_SLOW = 11,
  parameter int unsigned WRITE_SLOW = 24,
  parameter int unsigned READ_SLOW  = 24
) (
  input  logic CLK_IN,
  input  logic RST_IN,
  output logic TM1638_STB,
  output logic TM1638_CLK,
  inout  wire  TM1638_DIO
);

  localparam logic [15:0] RWAIT = 16'(READ_SLOW);

  top_state_t  state, state_d;
  logic [2:0]  step, step_d;
  logic        busy, busy_d;
  logic [15:0] wcnt, wcnt_d;
  logic [7:0]  key, key_d;
  logic [7:0]  acc, acc_d;
  logic [2:0]  digit, digit_d;
  logic        ser_start, start_d;
  logic [7:0]  ser_tx, tx_d;
  dir_t        ser_dir, dir_d;
  logic        ser_keep, keep_d;

  logic        done;
  logic [7:0]  rx;
  logic        rx_unused;

  logic        req;
  logic [7:0]  req_tx;
  dir_t        req_dir;
  logic        req_keep;
  logic [3:0]  nib;
  logic [1:0]  bidx;
  logic [7:0]  acc_new;
  logic        fin;

  assign rx_unused = ^{rx[7:5], rx[3:1]};

  tm1638_serial #(
    .CLOCK_SLOW(CLOCK_SLOW),
    .WRITE_SLOW(WRITE_SLOW)
  ) u_serial (
    .clk  (CLK_IN),
    .rst_n(RST_IN),
    .start(ser_start),
    .tx   (ser_tx),
    .dir  (ser_dir),
    .keep (ser_keep),
    .done (done),
    .rx   (rx),
    .stb  (TM1638_STB),
    .sclk (TM1638_CLK),
    .dio  (TM1638_DIO)
  );

  // Sequencer registers; key value and digit index clear on reset
  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) begin
      state     <= RESET_WAIT;
      step      <= '0;
      busy      <= 1'b0;
      wcnt      <= '0;
      key       <= '0;
      acc       <= '0;
      digit     <= '0;
      ser_start <= 1'b0;
      ser_tx    <= '0;
      ser_dir   <= DIR_WRITE;
      ser_keep  <= 1'b0;
    end else begin
      state     <= state_d;
      step      <= step_d;
      busy      <= busy_d;
      wcnt      <= wcnt_d;
      key       <= key_d;
      acc       <= acc_d;
      digit     <= digit_d;
      ser_start <= start_d;
      ser_tx    <= tx_d;
      ser_dir   <= dir_d;
      ser_keep  <= keep_d;
    end
  end

  // Byte request for the current state/step (what the engine should send next)
  always_comb begin
    req      = 1'b0;
    req_tx   = '0;
    req_dir  = DIR_WRITE;
    req_keep = 1'b0;
    case (digit)
      3'd7:    nib = key[3:0];
      3'd6:    nib = key[7:4];
      default: nib = 4'h0;
    endcase
    case (state)
      INIT: begin
        req    = 1'b1;
        req_tx = CMD_DISP_ON;
      end
      READ: begin
        if (step == 3'd0) begin
          req      = 1'b1;
          req_tx   = CMD_READ;
          req_keep = 1'b1;
        end else if (step >= 3'd2) begin
          req      = 1'b1;
          req_dir  = DIR_READ;
          req_keep = (step != 3'd5);
        end
      end
      MODE: begin
        req    = 1'b1;
        req_tx = CMD_WRITE_FIXED;
      end
      DIGIT: begin
        req = 1'b1;
        if (step == 3'd0) begin
          req_tx   = CMD_ADDR_BASE | {4'b0, digit, 1'b0};
          req_keep = 1'b1;
        end else begin
          req_tx = hex_to_seg(nib);
        end
      end
`ifdef TM1638_LED_EN
      LED: begin
        req = 1'b1;
        if (step == 3'd0) begin
          req_tx   = CMD_ADDR_BASE | {4'b0, digit, 1'b1};
          req_keep = 1'b1;
        end else begin
          req_tx = {7'b0, key[digit]};
        end
      end
`endif
      default: ;
    endcase
  end

  // Frame sequencing; read bytes accumulate into acc and K commits at frame end
  always_comb begin
    state_d = state;
    step_d  = step;
    busy_d  = busy;
    wcnt_d  = wcnt;
    key_d   = key;
    acc_d   = acc;
    digit_d = digit;
    start_d = 1'b0;
    tx_d    = ser_tx;
    dir_d   = ser_dir;
    keep_d  = ser_keep;
    // read byte i lives at step i+2
    bidx    = step[1:0] - 2'd2;
    acc_new = acc;
    acc_new[{1'b0, bidx}] = rx[4];
    acc_new[{1'b1, bidx}] = rx[0];
    fin     = busy && done;

    if (!busy && req) begin
      start_d = 1'b1;
      busy_d  = 1'b1;
      tx_d    = req_tx;
      dir_d   = req_dir;
      keep_d  = req_keep;
    end
    if (fin) begin
      busy_d = 1'b0;
      step_d = step + 3'd1;
    end

    case (state)
      RESET_WAIT: begin
        state_d = INIT;
        step_d  = '0;
      end
      INIT: begin
        if (fin) begin
          state_d = READ;
          step_d  = '0;
        end
      end
      READ: begin
        if (step == 3'd1) begin
          if (wcnt == RWAIT) begin
            wcnt_d = '0;
            step_d = 3'd2;
          end else begin
            wcnt_d = wcnt + 16'd1;
          end
        end
        if (fin && step >= 3'd2) begin
          acc_d = acc_new;
          if (step == 3'd5) begin
            key_d   = acc_new;
            state_d = MODE;
            step_d  = '0;
          end
        end
      end
      MODE: begin
        if (fin) begin
          state_d = DIGIT;
          step_d  = '0;
        end
      end
      DIGIT: begin
        if (fin && step == 3'd1) begin
          step_d = '0;
`ifdef TM1638_LED_EN
          state_d = LED;
`else
          state_d = READ;
          digit_d = digit + 3'd1;
`endif
        end
      end
`ifdef TM1638_LED_EN
      LED: begin
        if (fin && step == 3'd1) begin
          step_d  = '0;
          state_d = READ;
          digit_d = digit + 3'd1;
        end
      end
`endif
      default: state_d = RESET_WAIT;
    endcase
  end

endmodule

// File: tb/tb_tm1638_btm_disp.sv
// Bench for tm1638_btm_disp: a bus monitor decodes every frame, plays the
// TM1638 device for key reads, and compares written bytes against a queue
// of expected bytes pushed by the stimulus process.
`timescale 1ns/1ps
module tb_tm1638_btm_disp;

  localparam int unsigned CS = 1;
  localparam int unsigned WS = 3;
  localparam int unsigned RS = 2;
`ifdef TM1638_LED_EN
  localparam int LEFT_AFTER_ADDR = 3;
`else
  localparam int LEFT_AFTER_ADDR = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  wire  stb, sclk, dio;

  logic mon_oe = 1'b0, mon_out = 1'b0;
  logic rst_oe = 1'b0, rst_out = 1'b0;
  assign dio = mon_oe ? mon_out : (rst_oe ? rst_out : 1'bz);

  always #5 clk = ~clk;

  tm1638_btm_disp #(
    .CLOCK_SLOW(CS),
    .WRITE_SLOW(WS),
    .READ_SLOW (RS)
  ) dut (
    .CLK_IN    (clk),
    .RST_IN    (rst_n),
    .TM1638_STB(stb),
    .TM1638_CLK(sclk),
    .TM1638_DIO(dio)
  );

  int total = 0, bad = 0;
  int tmo_count = 0;
  logic fin_req = 1'b0;
  logic [8:0] exp_q[$];
  logic [7:0] rd[4];
  logic [7:0] seg_tab[16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                              8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // {first byte of frame, value}
  task automatic push(input logic first, input logic [7:0] b);
    exp_q.push_back({first, b});
  endtask

  // One main-loop iteration for digit d with key value k (K[3:0] on digit 7, K[7:4] on digit 6)
  task automatic push_iter(input int unsigned d, input logic [7:0] k);
    logic [3:0] nib;
    nib = (d == 7) ? k[3:0] : ((d == 6) ? k[7:4] : 4'h0);
    push(1'b1, 8'h42);
    push(1'b1, 8'h44);
    push(1'b1, 8'hC0 | 8'(d * 2));
    push(1'b0, seg_tab[nib]);
`ifdef TM1638_LED_EN
    push(1'b1, 8'hC1 | 8'(d * 2));
    push(1'b0, {7'b0, k[d]});
`endif
  endtask

  task automatic wait_q(input int target);
    int n;
    n = 0;
    while (exp_q.size() != target && n < 20000) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != target) tmo_count++;
  endtask

  // Monitor / device model / scoreboard checker
  logic prev_stb = 1'b1, prev_sclk = 1'b1;
  logic in_frame = 1'b0, is_read = 1'b0, first_fall = 1'b0, gap_valid = 1'b0;
  int   bitcnt = 0, byte_idx = 0, setup_cnt = 0, high_cnt = 0, wait_cnt = 0;
  logic [7:0] sh = '0;
  logic [8:0] e;

  always @(negedge clk) begin
    if (fin_req) begin
      check("wait_bounds", 32'(tmo_count), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
    if (!rst_n) begin
      check("rst_stb", {31'b0, stb}, 32'd1);
      check("rst_clk", {31'b0, sclk}, 32'd1);
      if (rst_oe) check("rst_dio_released", {31'b0, dio}, {31'b0, rst_out});
      in_frame = 1'b0; is_read = 1'b0; first_fall = 1'b0; gap_valid = 1'b0;
      bitcnt = 0; byte_idx = 0; mon_oe = 1'b0;
    end else begin
      if (stb) high_cnt++;
      setup_cnt++;
      wait_cnt++;
      if (prev_stb && !stb) begin
        if (gap_valid) check("stb_high_gap", {31'b0, high_cnt >= int'(WS + 1)}, 32'd1);
        in_frame = 1'b1; is_read = 1'b0; first_fall = 1'b1;
        bitcnt = 0; byte_idx = 0; setup_cnt = 0;
      end
      if (sclk != prev_sclk) check("stb_low_at_clk_edge", {31'b0, stb}, 32'd0);
      if (prev_sclk && !sclk && in_frame) begin
        if (first_fall) begin
          check("stb_to_clk_setup", {31'b0, setup_cnt >= int'(CS + 1)}, 32'd1);
          first_fall = 1'b0;
        end
        if (is_read && byte_idx >= 1 && byte_idx <= 4) begin
          if (byte_idx == 1 && bitcnt == 0)
            check("read_wait", {31'b0, wait_cnt >= int'(RS + 1)}, 32'd1);
          mon_oe  = 1'b1;
          mon_out = rd[byte_idx - 1][bitcnt];
        end
      end
      if (!prev_sclk && sclk && in_frame) begin
        sh = {dio, sh[7:1]};
        bitcnt++;
        if (bitcnt == 8) begin
          bitcnt = 0;
          if (byte_idx == 0 || !is_read) begin
            check("byte_expected", {31'b0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              check("bus_byte", {23'b0, byte_idx == 0, sh}, {23'b0, e});
            end
            if (byte_idx == 0 && sh == 8'h42) begin
              is_read  = 1'b1;
              wait_cnt = 0;
            end
          end else begin
            mon_oe = 1'b0;
          end
          byte_idx++;
        end
      end
      if (!prev_stb && stb) begin
        check("frame_whole_bytes", 32'(bitcnt), 32'd0);
        if (is_read) check("read_frame_len", 32'(byte_idx), 32'd5);
        in_frame = 1'b0; high_cnt = 0; gap_valid = 1'b1; mon_oe = 1'b0;
      end
    end
    prev_stb  = stb;
    prev_sclk = sclk;
  end

  // Stimulus: reset, two key patterns, mid-frame reset, restart
  initial begin
    rst_n = 1'b0;
    rd = '{8'h01, 8'h00, 8'h00, 8'h10};
    rst_oe = 1'b1; rst_out = 1'b0;
    repeat (3) @(posedge clk);
    rst_out = 1'b1;
    repeat (3) @(posedge clk);
    rst_oe = 1'b0;
    push(1'b1, 8'h8F);
    for (int i = 0; i < 9; i++) push_iter(i % 8, 8'h18);
    @(posedge clk);
    #2 rst_n = 1'b1;
    wait_q(0);

    rd = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    for (int i = 1; i < 9; i++) push_iter(i % 8, 8'hFF);
    wait_q(0);

    push_iter(1, 8'hFF);
    wait_q(LEFT_AFTER_ADDR);
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    rst_oe = 1'b1; rst_out = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    rst_out = 1'b0;
    repeat (2) @(posedge clk);
    rst_oe = 1'b0;
    rd = '{8'h01, 8'h00, 8'h00, 8'h10};
    push(1'b1, 8'h8F);
    push_iter(0, 8'h18);
    push_iter(1, 8'h18);
    @(posedge clk);
    #2 rst_n = 1'b1;
    wait_q(0);
    repeat (20) @(posedge clk);
    fin_req = 1'b1;
  end

endmodule
